// File: rtl/port_ingress_buffer_if.sv
// -----------------------------------------------------------------------------
// port_ingress_buffer_if
// Bundles the two handshakes that go through one ingress port:
//   host side   : in_valid / in_ready / in_rx_port / in_data (write into FIFO)
//   fabric side : slot_start / grant from scheduler+arbiter,
//                 port_out / req_valid to the sorting network
// master = host/scheduler driver, slave = the ingress buffer.
// -----------------------------------------------------------------------------
interface port_ingress_buffer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int PORT_NUB   = 16
);
  localparam int PW         = $clog2(PORT_NUB);
  localparam int WIDTH_PORT = 2*PW + DATA_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [PW-1:0]         in_rx_port;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  slot_start;
  logic                  grant;
  logic [WIDTH_PORT-1:0] port_out;
  logic                  req_valid;

  modport master (
    output in_valid, in_rx_port, in_data, slot_start, grant,
    input  in_ready, port_out, req_valid
  );

  modport slave (
    input  in_valid, in_rx_port, in_data, slot_start, grant,
    output in_ready, port_out, req_valid
  );
endinterface

// File: rtl/port_ingress_buffer.sv
// -----------------------------------------------------------------------------
// port_ingress_buffer
// Per-input-port ingress stage of the switching fabric. Host writes land in a
// FIFO of {rx_port, data}; each switching slot the head is offered to the
// sorting network as {rx_port, PORT_ID, data} and held until granted. With
// nothing to offer, a self-addressed idle word {PORT_ID, PORT_ID, 0} is driven.
//
// Ports:
//   clk, rst_n  : fabric clock, synchronous active-low reset
//   bus (slave) : host write handshake + slot/grant/port_out/req_valid
//   fifo_count  : current FIFO occupancy (registered)
//   drop_err    : one-cycle pulse after a loopback write was discarded
//   stall_cnt   : slots lost by the current head packet, saturating at 255
// -----------------------------------------------------------------------------
module port_ingress_buffer #(
  parameter  int DATA_WIDTH = 128,
  parameter  int PORT_NUB   = 16,
  parameter  int PORT_ID    = 0,
  parameter  int FIFO_DEPTH = 8,
  localparam int PW         = $clog2(PORT_NUB),
  localparam int CW         = $clog2(FIFO_DEPTH) + 1,
  localparam int WIDTH_PORT = 2*PW + DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  port_ingress_buffer_if.slave         bus,
  output logic [CW-1:0]                fifo_count,
  output logic                         drop_err,
  output logic [7:0]                   stall_cnt
);

  localparam int                    PTRW     = CW - 1;
  localparam int                    EW       = PW + DATA_WIDTH;
  localparam logic [PW-1:0]         MY_ID    = PW'(PORT_ID);
  localparam logic [WIDTH_PORT-1:0] IDLE_PKT = {MY_ID, MY_ID, {DATA_WIDTH{1'b0}}};

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  // Storage and pointers
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [PTRW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_drop_err;

  // Offer FSM
  state_t                r_state;
  logic [WIDTH_PORT-1:0] r_port_out;
  logic                  r_req_valid;
  logic [7:0]            r_stall;

  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_loopback;
  logic                  w_store;
  logic                  w_pop;
  logic [PTRW-1:0]       w_rd_nxt;

  // Insert tx_port between destination and payload.
  function automatic logic [WIDTH_PORT-1:0] fmt(input logic [EW-1:0] e);
    return {e[EW-1:DATA_WIDTH], MY_ID, e[DATA_WIDTH-1:0]};
  endfunction

  // Gated by rst_n so no write completes during reset.
  assign w_in_ready = (r_count != CW'(FIFO_DEPTH)) && rst_n;
  assign w_push     = bus.in_valid && w_in_ready;
  // A loopback write completes its handshake but is never stored.
  assign w_loopback = (bus.in_rx_port == MY_ID);
  assign w_store    = w_push && !w_loopback;
  // The offered packet stays in the FIFO until granted, so OFFER implies count >= 1.
  assign w_pop      = (r_state == S_OFFER) && bus.grant;
  assign w_rd_nxt   = r_rd_ptr + 1'b1;

  // FIFO array: no reset needed, contents are qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= {bus.in_rx_port, bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= w_rd_nxt;
      r_count    <= r_count + CW'(w_store) - CW'(w_pop);
      r_drop_err <= w_push && w_loopback;
    end
  end

  // Decisions use the registered count, so a packet pushed this cycle is
  // not visible to a slot_start in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_port_out  <= IDLE_PKT;
      r_req_valid <= 1'b0;
      r_stall     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.slot_start && (r_count != '0)) begin
            r_port_out  <= fmt(r_mem[r_rd_ptr]);
            r_req_valid <= 1'b1;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (bus.grant) begin
            r_stall <= 8'd0;
            // Back-to-back: new slot opens as the head leaves; the next entry
            // is already in the array because it was counted last cycle.
            if (bus.slot_start && (r_count > CW'(1))) begin
              r_port_out <= fmt(r_mem[w_rd_nxt]);
            end else begin
              r_port_out  <= IDLE_PKT;
              r_req_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else if (bus.slot_start) begin
            if (r_stall != 8'hFF) r_stall <= r_stall + 8'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_port_out  <= IDLE_PKT;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.port_out  = r_port_out;
  assign bus.req_valid = r_req_valid;
  assign fifo_count    = r_count;
  assign drop_err      = r_drop_err;
  assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// -----------------------------------------------------------------------------
// tb_port_ingress_buffer
// Directed bench for port_ingress_buffer with PORT_ID = 3. Stimulus pushes the
// expected network word of every stored packet into a scoreboard queue; a
// negedge monitor pops and compares on every granted offer, and checks that
// the idle word is driven whenever req_valid is low.
// -----------------------------------------------------------------------------
module tb_port_ingress_buffer;
  localparam int DW  = 128;
  localparam int PN  = 16;
  localparam int PID = 3;
  localparam int FD  = 8;
  localparam int PW  = 4;
  localparam int CW  = 4;
  localparam int WP  = 2*PW + DW;
  localparam logic [WP-1:0] IDLE = {4'd3, 4'd3, 128'd0};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] fifo_count;
  logic          drop_err;
  logic [7:0]    stall_cnt;

  port_ingress_buffer_if #(.DATA_WIDTH(DW), .PORT_NUB(PN)) bus ();

  port_ingress_buffer #(
    .DATA_WIDTH(DW), .PORT_NUB(PN), .PORT_ID(PID), .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fifo_count(fifo_count),
    .drop_err  (drop_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  logic [WP-1:0] exp_q [$];
  logic [WP-1:0] m_exp;
  logic [WP-1:0] pkt;

  function automatic logic [WP-1:0] mk(input logic [3:0] rx, input logic [DW-1:0] d);
    return {rx, 4'd3, d};
  endfunction

  task automatic chk(input string nm, input logic [WP-1:0] act, input logic [WP-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] rx, input logic [DW-1:0] d);
    bus.in_valid   = 1'b1;
    bus.in_rx_port = rx;
    bus.in_data    = d;
    chk("in_ready_at_push", WP'(bus.in_ready), WP'(1));
    if (rx != 4'd3) exp_q.push_back(mk(rx, d));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.req_valid && bus.grant) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grant_pkt: got %h, expected no packet", bus.port_out);
        end else begin
          m_exp = exp_q.pop_front();
          chk("grant_pkt", bus.port_out, m_exp);
        end
      end else if (!bus.req_valid) begin
        chk("idle_pkt", bus.port_out, IDLE);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_rx_port = '0;
    bus.in_data    = '0;
    bus.slot_start = 1'b0;
    bus.grant      = 1'b0;

    // ---------------- reset state
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_in_ready",   WP'(bus.in_ready),  WP'(0));
    chk("rst_port_out",   bus.port_out,       IDLE);
    chk("rst_req_valid",  WP'(bus.req_valid), WP'(0));
    chk("rst_fifo_count", WP'(fifo_count),    WP'(0));
    chk("rst_drop_err",   WP'(drop_err),      WP'(0));
    chk("rst_stall_cnt",  WP'(stall_cnt),     WP'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", WP'(bus.in_ready), WP'(1));

    // ---------------- single packet: push t, slot t+1, grant t+3
    push(4'd5, 128'hA5);                       // cycle t
    chk("single_count1", WP'(fifo_count), WP'(1));
    bus.slot_start = 1'b1;                     // cycle t+1
    tick();
    bus.slot_start = 1'b0;                     // now t+2
    chk("single_pkt_t2",   bus.port_out,       mk(4'd5, 128'hA5));
    chk("single_valid_t2", WP'(bus.req_valid), WP'(1));
    tick();                                    // now t+3
    chk("single_pkt_t3",   bus.port_out,       mk(4'd5, 128'hA5));
    bus.grant = 1'b1;
    tick();                                    // now t+4
    bus.grant = 1'b0;
    chk("single_idle_t4",  bus.port_out,       IDLE);
    chk("single_valid_t4", WP'(bus.req_valid), WP'(0));
    chk("single_count0",   WP'(fifo_count),    WP'(0));

    // ---------------- lost arbitration
    pkt = mk(4'd7, 128'h1234);
    push(4'd7, 128'h1234);
    bus.slot_start = 1'b1;
    tick();
    bus.slot_start = 1'b0;
    chk("stall_start", WP'(stall_cnt), WP'(0));
    for (int k = 1; k <= 3; k++) begin
      bus.slot_start = 1'b1;
      tick();
      bus.slot_start = 1'b0;
      chk("stall_inc",      WP'(stall_cnt), WP'(k));
      chk("stall_pkt_hold", bus.port_out,   pkt);
    end
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    chk("stall_clear", WP'(stall_cnt), WP'(0));

    // 300 losses saturate at 255
    pkt = mk(4'd9, 128'h5A5A);
    push(4'd9, 128'h5A5A);
    bus.slot_start = 1'b1;
    tick();
    repeat (300) tick();
    bus.slot_start = 1'b0;
    chk("stall_sat",     WP'(stall_cnt), WP'(255));
    chk("stall_sat_pkt", bus.port_out,   pkt);
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    chk("stall_sat_clear", WP'(stall_cnt), WP'(0));

    // ---------------- fill and back-to-back drain
    for (int i = 0; i < 8; i++) push(4'(4 + i), DW'(32'h100 + i));
    chk("fill_count8", WP'(fifo_count), WP'(8));
    bus.in_valid   = 1'b1;
    bus.in_rx_port = 4'd12;
    bus.in_data    = 128'hBAD;
    #1;
    chk("full_in_ready", WP'(bus.in_ready), WP'(0));
    tick();
    bus.in_valid = 1'b0;
    chk("full_no_push", WP'(fifo_count), WP'(8));
    bus.slot_start = 1'b1;
    tick();
    bus.grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_no_gap", WP'(bus.req_valid), WP'(1));
      tick();
      if (i == 0) chk("drain_in_ready", WP'(bus.in_ready), WP'(1));
    end
    bus.grant      = 1'b0;
    bus.slot_start = 1'b0;
    chk("drain_idle_valid", WP'(bus.req_valid), WP'(0));
    chk("drain_count0",     WP'(fifo_count),    WP'(0));

    // ---------------- loopback drop
    push(4'd3, 128'hDEAD);
    chk("loop_drop_pulse", WP'(drop_err),   WP'(1));
    chk("loop_count0",     WP'(fifo_count), WP'(0));
    tick();
    chk("loop_drop_end",   WP'(drop_err),   WP'(0));
    bus.slot_start = 1'b1;
    tick();
    bus.slot_start = 1'b0;
    chk("loop_no_req",     WP'(bus.req_valid), WP'(0));

    // ---------------- simultaneous push/pop at count 4, pointer wrap
    for (int i = 0; i < 4; i++) push(4'(4 + i), DW'(32'h3000 + i));
    bus.slot_start = 1'b1;
    tick();
    bus.grant = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_rx_port = 4'(4 + (i % 12));
      bus.in_data    = DW'(32'h4000 + i);
      exp_q.push_back(mk(4'(4 + (i % 12)), DW'(32'h4000 + i)));
      tick();
      chk("pp_count4", WP'(fifo_count),    WP'(4));
      chk("pp_valid",  WP'(bus.req_valid), WP'(1));
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    bus.grant      = 1'b0;
    bus.slot_start = 1'b0;
    chk("pp_count0", WP'(fifo_count),    WP'(0));
    chk("pp_idle",   WP'(bus.req_valid), WP'(0));

    // ---------------- reset mid-OFFER with count 3
    for (int i = 0; i < 3; i++) push(4'(8 + i), DW'(32'h5000 + i));
    bus.slot_start = 1'b1;
    tick();
    bus.slot_start = 1'b0;
    chk("pre_rst_count", WP'(fifo_count),    WP'(3));
    chk("pre_rst_valid", WP'(bus.req_valid), WP'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready", WP'(bus.in_ready), WP'(0));
    tick();
    rst_n = 1'b1;
    chk("mid_rst_port_out", bus.port_out,       IDLE);
    chk("mid_rst_valid",    WP'(bus.req_valid), WP'(0));
    chk("mid_rst_count",    WP'(fifo_count),    WP'(0));
    chk("mid_rst_stall",    WP'(stall_cnt),     WP'(0));
    bus.slot_start = 1'b1;
    tick();
    bus.slot_start = 1'b0;
    chk("no_stale_valid", WP'(bus.req_valid), WP'(0));
    push(4'd14, 128'hC0FFEE);
    bus.slot_start = 1'b1;
    tick();
    bus.slot_start = 1'b0;
    chk("post_rst_pkt", bus.port_out, mk(4'd14, 128'hC0FFEE));
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    tick();

    chk("scoreboard_empty", WP'(exp_q.size()), WP'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
